// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : Parameterised register file with one write port and two
//                registered read ports (1-cycle read latency). Read data is
//                held until the next edge on which that port's read enable is
//                high. Asynchronous active-low reset clears every entry and
//                both read-data registers.
//
//  Parameters  : WIDTH   - data width in bits
//                AW      - address width; depth is 2**AW entries
//                ZERO_R0 - when nonzero, entry 0 is hardwired to zero
//
//  Ports       : clk              - clock, all state updates on rising edge
//                rst_n            - asynchronous active-low reset
//                we/waddr/wdata   - write port
//                re0/raddr0       - read port 0 enable/address
//                re1/raddr1       - read port 1 enable/address
//                rdata0/rdata1    - registered read data
//
//  Build macro : REGFILE_BYPASS_EN - when defined, a read of the address
//                being written on the same edge captures the new write data;
//                when undefined it captures the pre-write (old) contents.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int WIDTH   = 32,
    parameter int AW      = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re0,
    input  logic [AW-1:0]    raddr0,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    localparam int c_depth   = 1 << AW;
    localparam bit c_zero_r0 = (ZERO_R0 != 0);

    logic [WIDTH-1:0] r_mem [c_depth];
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;

    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd0;
    logic [WIDTH-1:0] w_rd1;

    // Writes to entry 0 are dropped when it is hardwired to zero. Because
    // that entry is cleared by reset and never written afterwards, it
    // always reads as zero without any extra masking on the read path, and
    // the bypass below can never forward data into it either.
    assign w_wr_en = we && !(c_zero_r0 && (waddr == '0));

    always_comb begin
        w_rd0 = r_mem[raddr0];
        w_rd1 = r_mem[raddr1];
`ifdef REGFILE_BYPASS_EN
        // Same-edge read of the entry being written returns the new data.
        if (w_wr_en && (waddr == raddr0)) begin
            w_rd0 = wdata;
        end
        if (w_wr_en && (waddr == raddr1)) begin
            w_rd1 = wdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[waddr] <= wdata;
            end
            if (re0) begin
                r_rdata0 <= w_rd0;
            end
            if (re1) begin
                r_rdata1 <= w_rd1;
            end
        end
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 The block SHALL have parameter AW, default 4, address width; depth is 2**AW entries.
REQ-003 The block SHALL have parameter ZERO_R0, default 0; when 1, entry 0 is hardwired to zero.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 we  input  1  write enable.
REQ-007 waddr  input  AW  write address.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 re0, re1  input  1 each  read enable, ports 0 and 1.
REQ-010 raddr0, raddr1  input  AW each  read address, ports 0 and 1.
REQ-011 rdata0, rdata1  output  WIDTH each  registered read data, ports 0 and 1.

Function
REQ-012 Write: at a clk edge with we=1, entry[waddr] SHALL take wdata; with we=0, no entry changes.
REQ-013 When ZERO_R0=1, a write to address 0 SHALL be discarded, and entry 0 SHALL always read as 0.
REQ-014 Read: at a clk edge with reN=1, rdataN SHALL take entry[raddrN] and hold it until the next edge with reN=1 (1-cycle latency).
REQ-015 With reN=0, rdataN SHALL hold its previous value regardless of writes to the previously read address.
REQ-016 Both read ports SHALL be independent; equal raddr0 and raddr1 in the same cycle SHALL return identical data on both ports.
REQ-017 Read and write on different addresses in the same cycle SHALL not interact.
REQ-018 Same-address read and write in the same cycle SHALL follow the REQ-026 and REQ-027 rule.
REQ-019 Addresses SHALL be fully decoded; every AW-bit value SHALL select a distinct entry with no aliasing or wrap.

Reset
REQ-020 While rst_n=0, every entry SHALL be 0, asynchronously and independent of clk.
REQ-021 While rst_n=0, rdata0 and rdata1 SHALL be 0.
REQ-022 Writes and reads presented while rst_n=0 SHALL have no effect.
REQ-023 Reset asserted between a write edge and a later read SHALL cause that read to return 0.
REQ-024 The first edge after rst_n rises SHALL perform normal writes and reads.

Configuration
REQ-025 The macro REGFILE_BYPASS_EN SHALL select write-to-read bypass.
REQ-026 With REGFILE_BYPASS_EN defined, a port with reN=1 and raddrN==waddr, in the same edge as we=1, SHALL capture wdata (new data). The exception is address 0 when ZERO_R0=1, which SHALL return 0.
REQ-027 With REGFILE_BYPASS_EN undefined, the same case SHALL capture the pre-write entry value (old data), and the entry SHALL update normally.

Verification
REQ-028 Reset then read all 16 addresses on both ports -> every rdata is 0x00000000 one cycle after each read edge.
REQ-029 Write 0xDEADBEEF to addr 5, then re0=1 raddr0=5 and re1=1 raddr1=5 on the next edge -> rdata0 = rdata1 = 0xDEADBEEF after that edge.
REQ-030 Addr 3 holds 0x11111111; write 0x22222222 to addr 3 with re0=1 raddr0=3 on the same edge -> rdata0 = 0x22222222 with REGFILE_BYPASS_EN defined, 0x11111111 without it; the next read of addr 3 returns 0x22222222 in both builds.
REQ-031 ZERO_R0=1: write 0xFFFFFFFF to addr 0, then read addr 0 -> rdata = 0; ZERO_R0=0 -> rdata = 0xFFFFFFFF.
REQ-032 Read addr 7 (holds 0xA5A5A5A5) with re0=1, then re0=0 while writing 0x0 to addr 7 -> rdata0 stays 0xA5A5A5A5.
REQ-033 Write 0x12345678 to addr 15, assert rst_n=0 mid-cycle with no clk edge -> rdata0 and rdata1 go 0 immediately; after release, reading addr 15 returns 0.
